// File: rtl/seg_muldiv_pkg.sv
// rtl/seg_muldiv_pkg.sv - op codes and FSM states shared by the multiply/divide unit
package seg_muldiv_pkg;

  localparam logic [2:0] MD_NOP   = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // The reserved code behaves exactly like NOP.
  function automatic logic md_is_nop(input logic [2:0] op);
    return (op == MD_NOP) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/seg_execute_muldiv_iter.sv
// rtl/seg_execute_muldiv_iter.sv - unsigned shift-add / restoring shift-subtract datapath
module seg_execute_muldiv_iter #(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo,
  output logic               o_last
);

  logic [NB_DATA-1:0] r_acc;
  logic [NB_DATA-1:0] r_q;
  logic [NB_DATA-1:0] r_b;
  logic [NB_CNT-1:0]  r_cnt;
  logic               r_div;

  logic [NB_DATA:0]   w_mul_sum;
  logic [NB_DATA:0]   w_div_shift;
  logic               w_div_ok;
  logic [NB_DATA-1:0] w_div_sub;

  // Multiply: {acc, q} holds partial product and remaining multiplier bits.
  assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(NB_DATA+1){1'b0}});
  // Divide: acc is the partial remainder, q shifts dividend out and quotient in.
  assign w_div_shift = {r_acc, r_q[NB_DATA-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
  assign w_div_sub   = w_div_shift[NB_DATA-1:0] - r_b;

  assign o_hi   = r_acc;
  assign o_lo   = r_q;
  assign o_last = (r_cnt == NB_CNT'(NB_DATA - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_start) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_b   <= i_b;
      r_cnt <= '0;
      r_div <= i_div;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_div) begin
        r_acc <= w_div_ok ? w_div_sub : w_div_shift[NB_DATA-1:0];
        r_q   <= {r_q[NB_DATA-2:0], w_div_ok};
      end else begin
        r_acc <= w_mul_sum[NB_DATA:1];
        r_q   <= {w_mul_sum[0], r_q[NB_DATA-1:1]};
      end
    end
  end

endmodule

// File: rtl/seg_execute_muldiv.sv
// rtl/seg_execute_muldiv.sv - iterative MULT/DIV unit owning HI/LO with busy/stall handshake
module seg_execute_muldiv
  import seg_muldiv_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_MDOP = 3,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_valid,
  input  logic [NB_MDOP-1:0] i_op,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo,
  output logic               o_busy,
  output logic               o_stall,
  output logic               o_done,
  output logic               o_div_zero
);

  md_state_t          r_state;
  logic [NB_DATA-1:0] r_hi;
  logic [NB_DATA-1:0] r_lo;
  logic [NB_DATA-1:0] r_a_raw;
  logic               r_done;
  logic               r_div_zero;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_b_zero;

  logic                 w_is_md;
  logic                 w_signed;
  logic                 w_div_op;
  logic                 w_start;
  logic [NB_DATA-1:0]   w_a_mag;
  logic [NB_DATA-1:0]   w_b_mag;
  logic [NB_DATA-1:0]   w_it_hi;
  logic [NB_DATA-1:0]   w_it_lo;
  logic                 w_it_last;
  logic [2*NB_DATA-1:0] w_prod;
  logic [NB_DATA-1:0]   w_res_hi;
  logic [NB_DATA-1:0]   w_res_lo;

  assign w_is_md  = (i_op == MD_MULT) || (i_op == MD_MULTU) || (i_op == MD_DIV) || (i_op == MD_DIVU);
  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_div_op = (i_op == MD_DIV) || (i_op == MD_DIVU);
  assign w_start  = (r_state == ST_IDLE) && i_valid && !i_flush && w_is_md;

  // Most-negative input maps to itself, which is the correct unsigned magnitude.
  assign w_a_mag = (w_signed && i_data_a[NB_DATA-1]) ? (~i_data_a + 1'b1) : i_data_a;
  assign w_b_mag = (w_signed && i_data_b[NB_DATA-1]) ? (~i_data_b + 1'b1) : i_data_b;

  seg_execute_muldiv_iter #(
    .NB_DATA (NB_DATA),
    .NB_CNT  (NB_CNT)
  ) u_iter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (w_start),
    .i_step    (r_state == ST_CALC),
    .i_div     (w_div_op),
    .i_a       (w_a_mag),
    .i_b       (w_b_mag),
    .o_hi      (w_it_hi),
    .o_lo      (w_it_lo),
    .o_last    (w_it_last)
  );

  assign w_prod = r_neg_res ? (~{w_it_hi, w_it_lo} + 1'b1) : {w_it_hi, w_it_lo};

  always_comb begin
    w_res_hi = w_prod[2*NB_DATA-1:NB_DATA];
    w_res_lo = w_prod[NB_DATA-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_res_hi = r_a_raw;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_rem ? (~w_it_hi + 1'b1) : w_it_hi;
        w_res_lo = r_neg_res ? (~w_it_lo + 1'b1) : w_it_lo;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_a_raw    <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_b_zero   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      if (i_flush) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state   <= ST_CALC;
              r_a_raw   <= i_data_a;
              r_is_div  <= w_div_op;
              r_neg_res <= w_signed && (i_data_a[NB_DATA-1] ^ i_data_b[NB_DATA-1]);
              r_neg_rem <= w_signed && i_data_a[NB_DATA-1];
              r_b_zero  <= (i_data_b == '0);
            end else if (i_valid && (i_op == MD_MTHI)) begin
              r_hi <= i_data_a;
            end else if (i_valid && (i_op == MD_MTLO)) begin
              r_lo <= i_data_a;
            end
          end
          ST_CALC: begin
            if (w_it_last) r_state <= ST_FIX;
          end
          ST_FIX: begin
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_done     <= 1'b1;
            r_div_zero <= r_is_div && r_b_zero;
            r_state    <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_stall    = o_busy && i_valid && !md_is_nop(i_op);
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// tb/tb_seg_execute_muldiv.sv - directed self-checking bench for seg_execute_muldiv
module tb_seg_execute_muldiv;
  import seg_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  op = MD_NOP;
  logic        flush = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] o_hi, o_lo;
  logic        o_busy, o_stall, o_done, o_div_zero;

  int total = 0;
  int bad = 0;
  int n_cyc, n_stall, n_done;

  seg_execute_muldiv #(.NB_DATA(32), .NB_MDOP(3), .NB_CNT(6)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_valid    (valid),
    .i_op       (op),
    .i_flush    (flush),
    .i_data_a   (a),
    .i_data_b   (b),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .o_busy     (o_busy),
    .o_stall    (o_stall),
    .o_done     (o_done),
    .o_div_zero (o_div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
    op = t_op; a = t_a; b = t_b; valid = 1'b1;
    tick();
    valid = 1'b0; op = MD_NOP;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!o_done && n < 200) begin
      tick();
      n++;
    end
    check("done_seen", {63'd0, o_done}, 64'd1);
  endtask

  initial begin
    #12;
    check("rst_hi", 64'(o_hi), 64'd0);
    check("rst_lo", 64'(o_lo), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_dz", 64'(o_div_zero), 64'd0);
    rst_n = 1'b1;
    tick();

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    n_cyc = 0;
    while (o_busy && n_cyc < 100) begin
      n_cyc++;
      tick();
    end
    check("mult_busy_cycles", 64'(n_cyc), 64'd33);
    check("mult_done", 64'(o_done), 64'd1);
    check("mult_hi", 64'(o_hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(o_lo), 64'hFFFF_FFEB);
    check("mult_dz", 64'(o_div_zero), 64'd0);
    tick();
    check("mult_done_pulse", 64'(o_done), 64'd0);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done();
    check("multu_hi", 64'(o_hi), 64'h1);
    check("multu_lo", 64'(o_lo), 64'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    check("div_lo", 64'(o_lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(o_hi), 64'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd2);
    wait_done();
    check("divu_lo", 64'(o_lo), 64'd3);
    check("divu_hi", 64'(o_hi), 64'd1);

    issue(MD_DIVU, 32'h1234, 32'd0);
    wait_done();
    check("dz_flag", 64'(o_div_zero), 64'd1);
    check("dz_lo", 64'(o_lo), 64'hFFFF_FFFF);
    check("dz_hi", 64'(o_hi), 64'h1234);
    tick();
    check("dz_pulse", 64'(o_div_zero), 64'd0);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    check("ovf_lo", 64'(o_lo), 64'h8000_0000);
    check("ovf_hi", 64'(o_hi), 64'd0);
    check("ovf_flag", 64'(o_div_zero), 64'd0);

    // MULT accepted, then a DIVU held against the busy unit.
    op = MD_MULT; a = 32'd5; b = 32'd6; valid = 1'b1;
    tick();
    op = MD_DIVU; a = 32'd100; b = 32'd7;
    n_cyc = 0;
    n_stall = 0;
    while (o_busy && n_cyc < 100) begin
      n_cyc++;
      if (o_stall) n_stall++;
      tick();
    end
    check("stall_busy_cycles", 64'(n_cyc), 64'd33);
    check("stall_cycles", 64'(n_stall), 64'd33);
    check("b2b_done", 64'(o_done), 64'd1);
    check("b2b_stall_low", 64'(o_stall), 64'd0);
    check("b2b_mult_lo", 64'(o_lo), 64'd30);
    check("b2b_mult_hi", 64'(o_hi), 64'd0);
    tick();
    valid = 1'b0; op = MD_NOP;
    check("b2b_accept", 64'(o_busy), 64'd1);
    wait_done();
    check("b2b_divu_lo", 64'(o_lo), 64'd14);
    check("b2b_divu_hi", 64'(o_hi), 64'd2);

    issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0);
    check("mthi_hi", 64'(o_hi), 64'hA5A5_A5A5);
    check("mthi_busy", 64'(o_busy), 64'd0);
    check("mthi_done", 64'(o_done), 64'd0);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (9) tick();
    flush = 1'b1; valid = 1'b1; op = MD_MTLO; a = 32'd1;
    tick();
    flush = 1'b0; valid = 1'b0; op = MD_NOP;
    check("flush_busy", 64'(o_busy), 64'd0);
    check("flush_hi", 64'(o_hi), 64'hA5A5_A5A5);
    check("flush_lo", 64'(o_lo), 64'd14);
    n_done = 0;
    repeat (40) begin
      if (o_done || o_div_zero) n_done++;
      tick();
    end
    check("flush_no_done", 64'(n_done), 64'd0);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (5) tick();
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_hi", 64'(o_hi), 64'd0);
    check("mid_rst_lo", 64'(o_lo), 64'd0);
    check("mid_rst_done", 64'(o_done), 64'd0);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      tick();
      if (o_done || o_busy) n_done++;
    end
    check("post_rst_quiet", 64'(n_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
